// File: rtl/sha256_pkg.sv
// Shared constants and FSM state type for the streaming SHA-256 padder.
package sha256_pkg;
  localparam int WORD_W = 32;
  localparam int BLOCK_W = 512;
  localparam int LEN_W = 64;
  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam logic [WORD_W-1:0] PAD_WORD = {PAD_BYTE, 24'h0};

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_EMIT_SPILL, S_EMIT_LAST} state_e;
endpackage

// File: rtl/sha256_word_pad.sv
// Masks the unused bytes of a final message word and drops the 0x80 pad byte
// right after the last valid byte; flags when the word is full and the pad must move on.
module sha256_word_pad
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [2:0]        nbytes_i,
  output logic [WORD_W-1:0] word_o,
  output logic              spill_o
);
  logic [2:0] nb;

  assign nb      = (nbytes_i > 3'd4) ? 3'd4 : nbytes_i;
  assign spill_o = (nb == 3'd4);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_o[WORD_W-1-8*b -: 8] = (3'(b) < nb)  ? data_i[WORD_W-1-8*b -: 8] :
                                       (3'(b) == nb) ? PAD_BYTE : 8'h00;
  end
endmodule

// File: rtl/sha256_padder.sv
// Streaming FIPS 180-4 padder: packs 32-bit message words into 512-bit blocks,
// appends 0x80, zero fill and the bit length, spilling into an extra block if needed.
module sha256_padder #(
  parameter int LEN_W   = 64,
  parameter int BLOCK_W = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  input  logic [2:0]         in_nbytes,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_first,
  output logic               blk_last
);
  import sha256_pkg::*;

  state_e                         state_q, state_d;
  logic [NWORDS-1:0][WORD_W-1:0]  buf_q, buf_d;
  logic [3:0]                     widx_q, widx_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic                           first_q, first_d;
  logic                           pend80_q, pend80_d;

  logic [WORD_W-1:0] pad_word;
  logic              pad_spill;
  logic [2:0]        nb;
  logic [LEN_W-1:0]  len_fin;
  logic [63:0]       len64_fin, len64_q;
  logic [4:0]        used_idx;
  logic              fits;

  sha256_word_pad u_pad (
    .data_i   (in_data),
    .nbytes_i (in_nbytes),
    .word_o   (pad_word),
    .spill_o  (pad_spill)
  );

  assign nb        = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign len_fin   = len_q + LEN_W'({nb, 3'b000});
  assign len64_fin = 64'(len_fin);
  assign len64_q   = 64'(len_q);
  // Highest word touched by data or the pad byte; 14/15 are reserved for the length.
  assign used_idx  = {1'b0, widx_q} + {4'b0, pad_spill};
  assign fits      = (used_idx <= 5'd13);

  for (genvar i = 0; i < NWORDS; i++) begin : g_out
    assign blk_data[BLOCK_W-1-WORD_W*i -: WORD_W] = buf_q[i];
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    widx_d    = widx_q;
    len_d     = len_q;
    first_d   = first_q;
    pend80_d  = pend80_q;
    in_ready  = (state_q == S_FILL);
    blk_valid = (state_q != S_FILL);
    blk_first = blk_valid & first_q;
    blk_last  = (state_q == S_EMIT_LAST);

    unique case (state_q)
      S_FILL: begin
        if (in_valid && !in_last) begin
          buf_d[widx_q] = in_data;
          len_d         = len_q + LEN_W'(32);
          widx_d        = widx_q + 4'd1;
          if (widx_q == 4'd15) state_d = S_EMIT;
        end else if (in_valid) begin
          for (int i = 0; i < NWORDS; i++) begin
            if (4'(i) > widx_q) buf_d[i] = '0;
          end
          buf_d[widx_q] = pad_word;
          if (pad_spill) begin
            if (widx_q != 4'd15) buf_d[widx_q + 4'd1] = PAD_WORD;
            else                 pend80_d = 1'b1;
          end
          len_d  = len_fin;
          widx_d = '0;
          if (fits) begin
            buf_d[14] = len64_fin[63:32];
            buf_d[15] = len64_fin[31:0];
            state_d   = S_EMIT_LAST;
          end else begin
            state_d   = S_EMIT_SPILL;
          end
        end
      end
      S_EMIT: begin
        if (blk_ready) begin
          buf_d   = '0;
          widx_d  = '0;
          first_d = 1'b0;
          state_d = S_FILL;
        end
      end
      S_EMIT_SPILL: begin
        if (blk_ready) begin
          buf_d     = '0;
          buf_d[0]  = pend80_q ? PAD_WORD : '0;
          buf_d[14] = len64_q[63:32];
          buf_d[15] = len64_q[31:0];
          pend80_d  = 1'b0;
          first_d   = 1'b0;
          state_d   = S_EMIT_LAST;
        end
      end
      S_EMIT_LAST: begin
        if (blk_ready) begin
          buf_d   = '0;
          widx_d  = '0;
          len_d   = '0;
          first_d = 1'b1;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FILL;
      buf_q    <= '0;
      widx_q   <= '0;
      len_q    <= '0;
      first_q  <= 1'b1;
      pend80_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      widx_q   <= widx_d;
      len_q    <= len_d;
      first_q  <= first_d;
      pend80_q <= pend80_d;
    end
  end
endmodule

// File: tb/tb_sha256_padder.sv
// Randomized and directed checks of sha256_padder against a byte-level padding model.
module tb_sha256_padder;
  typedef byte unsigned bq_t[$];
  typedef struct packed { logic [511:0] d; logic f; logic l; } blk_t;
  typedef struct packed { logic [31:0] d; logic last; logic [2:0] nb; } wrd_t;
  typedef blk_t blk_q_t[$];
  typedef wrd_t wq_t[$];

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0, blk_valid, blk_ready = 1'b0;
  logic blk_first, blk_last;
  logic [31:0] in_data = '0;
  logic [2:0] in_nbytes = '0;
  logic [511:0] blk_data;
  int n_assert = 0, n_fail = 0;
  logic [511:0] got_blk[$];

  sha256_padder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Standard padding on the byte string: msg | 80 | 00.. | 64-bit big-endian bit length
  function automatic blk_q_t model(input bq_t msg);
    bq_t p = msg;
    blk_q_t q;
    blk_t b;
    logic [63:0] bl = 64'(msg.size()) << 3;
    int nblk;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    nblk = p.size() / 64;
    for (int bi = 0; bi < nblk; bi++) begin
      for (int j = 0; j < 64; j++) b.d[511-8*j -: 8] = p[64*bi+j];
      b.f = (bi == 0);
      b.l = (bi == nblk - 1);
      q.push_back(b);
    end
    return q;
  endfunction

  // mode 0: a whole-word ending rides on the last word (nbytes 4..7);
  // mode 1: it is followed by a separate nbytes=0 word. Unused bytes carry junk.
  function automatic wq_t frame(input bq_t msg, input int mode);
    wq_t w;
    wrd_t x;
    int L = msg.size();
    int nfull = L / 4;
    int rem = L % 4;
    int nrm = (rem == 0 && L > 0 && mode == 0) ? nfull - 1 : nfull;
    for (int i = 0; i < nrm; i++) begin
      x.d = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
      x.last = 1'b0;
      x.nb = 3'($urandom);
      w.push_back(x);
    end
    x.d = $urandom;
    x.last = 1'b1;
    if (rem != 0) begin
      for (int j = 0; j < rem; j++) x.d[31-8*j -: 8] = msg[4*nfull+j];
      x.nb = 3'(rem);
    end else if (L > 0 && mode == 0) begin
      for (int j = 0; j < 4; j++) x.d[31-8*j -: 8] = msg[4*(nfull-1)+j];
      x.nb = 3'($urandom_range(4, 7));
    end else begin
      x.nb = 3'd0;
    end
    w.push_back(x);
    return w;
  endfunction

  task automatic run_msg(input string tag, input bq_t msg, input int mode,
                         input int vp, input int rp, input int hold);
    wq_t w = frame(msg, mode);
    blk_q_t exp = model(msg);
    blk_t e;
    int wi = 0, cyc = 0, held = 0;
    logic prev_pend = 1'b0, prev_f = 1'b0, prev_l = 1'b0, ixf, bxf;
    logic [511:0] prev_d = '0;
    got_blk.delete();
    while ((wi < w.size() || exp.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (wi < w.size()) begin
        in_valid  = ($urandom_range(0, 99) < vp);
        in_data   = w[wi].d;
        in_last   = w[wi].last;
        in_nbytes = w[wi].nb;
      end else in_valid = 1'b0;
      blk_ready = ($urandom_range(0, 99) < rp);
      if (blk_valid && held < hold) begin
        blk_ready = 1'b0;
        if (wi < w.size()) in_valid = 1'b1;
        held++;
      end
      if (blk_valid) chk({tag, " in_ready while pending"}, 512'(in_ready), 512'(0));
      if (prev_pend) begin
        chk({tag, " held data"}, blk_data, prev_d);
        chk({tag, " held ctrl"}, 512'({blk_valid, blk_first, blk_last}), 512'({1'b1, prev_f, prev_l}));
      end
      bxf = blk_valid && blk_ready;
      ixf = in_valid && in_ready;
      if (bxf) begin
        if (exp.size() == 0) chk({tag, " extra block"}, 512'(1), 512'(0));
        else begin
          e = exp.pop_front();
          chk({tag, " data"}, blk_data, e.d);
          chk({tag, " first/last"}, 512'({blk_first, blk_last}), 512'({e.f, e.l}));
          got_blk.push_back(blk_data);
        end
      end
      prev_pend = blk_valid && !blk_ready;
      prev_d = blk_data;
      prev_f = blk_first;
      prev_l = blk_last;
      @(posedge clk);
      if (ixf) wi++;
    end
    chk({tag, " completed"}, 512'({wi == w.size(), exp.size() == 0}), 512'(2'b11));
    @(negedge clk);
    in_valid = 1'b0;
    blk_ready = 1'b0;
    chk({tag, " idle after"}, 512'({in_ready, blk_valid}), 512'(2'b10));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    blk_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset ctrl", 512'({in_ready, blk_valid, blk_first, blk_last}), 512'(4'b1000));
    chk("reset data", blk_data, '0);
  endtask

  function automatic bq_t rnd_msg(input int L);
    bq_t m;
    for (int i = 0; i < L; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  initial begin
    bq_t m;
    string s;
    logic [511:0] b0, b1, k;
    int lens[15] = '{0, 1, 3, 4, 52, 55, 56, 57, 60, 63, 64, 65, 119, 120, 128};

    do_reset();

    m = {8'h61, 8'h62, 8'h63};
    run_msg("abc", m, 0, 100, 100, 0);
    b0 = got_blk[0];
    k = {32'h61626380, 416'h0, 64'h18};
    chk("abc exact", b0, k);

    s = "Hello, SHA-256!";
    m.delete();
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    run_msg("hello", m, 0, 100, 100, 0);
    b0 = got_blk[0];
    chk("hello word3", 512'(b0[415:384]), 512'(32'h35362180));
    chk("hello word15", 512'(b0[31:0]), 512'(32'h00000078));

    m = rnd_msg(56);
    run_msg("len56", m, 0, 100, 100, 0);
    b0 = got_blk[0];
    b1 = got_blk[1];
    chk("len56 blk1 word14", 512'(b0[63:32]), 512'(32'h80000000));
    chk("len56 blk2", b1, 512'(64'h1C0));

    m = rnd_msg(64);
    run_msg("len64", m, 0, 100, 100, 0);
    b1 = got_blk[1];
    k = {32'h80000000, 448'h0, 32'h00000200};
    chk("len64 blk2", b1, k);

    m = rnd_msg(72);
    run_msg("backpressure", m, 0, 100, 100, 20);
    b1 = got_blk[1];
    chk("bp first word after accept", 512'(b1[511:480]), 512'({m[64], m[65], m[66], m[67]}));

    m.delete();
    run_msg("empty", m, 0, 100, 100, 0);
    b0 = got_blk[0];
    k = {32'h80000000, 480'h0};
    chk("empty exact", b0, k);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = $urandom;
      in_last = 1'b0;
      in_nbytes = 3'd0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    do_reset();
    m = {8'h61, 8'h62, 8'h63};
    run_msg("abc after reset", m, 0, 100, 100, 0);
    b0 = got_blk[0];
    k = {32'h61626380, 416'h0, 64'h18};
    chk("abc after reset exact", b0, k);

    foreach (lens[i]) begin
      for (int md = 0; md < 2; md++) begin
        m = rnd_msg(lens[i]);
        run_msg($sformatf("bound L=%0d m=%0d", lens[i], md), m, md,
                $urandom_range(30, 100), $urandom_range(30, 100), 0);
      end
    end

    for (int t = 0; t < 20; t++) begin
      int L = $urandom_range(0, 140);
      m = rnd_msg(L);
      run_msg($sformatf("rand L=%0d", L), m, $urandom_range(0, 1),
              $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
